// File: rtl/pkt_hdr_parse_pkg.sv
// rtl/pkt_hdr_parse_pkg.sv - shared state encoding and constants for the frame header parser
//
// Contents:
//   state_t           parser FSM encoding (HDR, SIZE, PAY, CHK)
//   DEFAULT_MAX_SIZE  default largest legal payload length
//   HDR_MSB_FIRST     byte order of the header length field
//   len_mask()        mask of the length bits that a SIZE_BYTES header can carry
package pkt_hdr_parse_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'b00,
    SIZE = 2'b01,
    PAY  = 2'b11,
    CHK  = 2'b10
  } state_t;

  localparam logic [31:0] DEFAULT_MAX_SIZE = 32'h0000_FFFF;

  // Length field arrives most significant byte first.
  localparam bit HDR_MSB_FIRST = 1'b1;

  // Upper length bits beyond SIZE_BYTES bytes are forced to zero.
  function automatic logic [31:0] len_mask(input int size_bytes);
    if (size_bytes >= 4) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << (8 * size_bytes)) - 32'd1;
  endfunction

endpackage

// File: rtl/pkt_hdr_shift.sv
// rtl/pkt_hdr_shift.sv - header length assembler with byte index and optional XOR checksum
//
// Optional feature macro: PKT_HDR_PARSE_CHK_EN (header carries one trailing XOR byte).
//
// Ports:
//   clock      in   system clock
//   rst_n      in   synchronous, active-low reset
//   byte_take  in   a header byte is accepted this cycle
//   byte_data  in   the accepted header byte
//   hdr_done   out  this accepted byte completes the header (combinational)
//   hdr_len    out  assembled length including this byte (meaningful with hdr_done)
//   chk_ok     out  checksum matches (always 1 when the checksum feature is off)
module pkt_hdr_shift
  import pkt_hdr_parse_pkg::*;
#(
  parameter int SIZE_BYTES = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        byte_take,
  input  logic [7:0]  byte_data,
  output logic        hdr_done,
  output logic [31:0] hdr_len,
  output logic        chk_ok
);

`ifdef PKT_HDR_PARSE_CHK_EN
  localparam int HDR_BYTES = SIZE_BYTES + 1;
`else
  localparam int HDR_BYTES = SIZE_BYTES;
`endif

  localparam logic [31:0] MASK     = len_mask(SIZE_BYTES);
  localparam logic [2:0]  LAST_IDX = 3'(HDR_BYTES - 1);

  logic [2:0]  idx_q;
  logic [31:0] len_q;
  logic [31:0] len_d;
  logic        is_len_byte;

  // The checksum byte (if any) sits after all length bytes.
  assign is_len_byte = (idx_q < 3'(SIZE_BYTES));
  assign hdr_done    = byte_take && (idx_q == LAST_IDX);
  assign hdr_len     = len_d;

  always_comb begin
    len_d = len_q;
    if (is_len_byte) begin
      if (HDR_MSB_FIRST) begin
        len_d = {len_q[23:0], byte_data} & MASK;
      end else begin
        len_d = len_q | ({24'd0, byte_data} << {idx_q, 3'b000});
      end
    end
  end

`ifdef PKT_HDR_PARSE_CHK_EN
  logic [7:0] xor_q;

  // Valid only on the checksum byte, where xor_q covers every length byte.
  assign chk_ok = (byte_data == xor_q);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      xor_q <= 8'd0;
    end else if (byte_take) begin
      if (hdr_done) begin
        xor_q <= 8'd0;
      end else if (is_len_byte) begin
        xor_q <= xor_q ^ byte_data;
      end
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
      len_q <= 32'd0;
    end else if (byte_take) begin
      if (hdr_done) begin
        idx_q <= 3'd0;
        len_q <= 32'd0;
      end else begin
        idx_q <= idx_q + 3'd1;
        len_q <= len_d;
      end
    end
  end

endmodule

// File: rtl/pkt_hdr_parse.sv
// rtl/pkt_hdr_parse.sv - length-header frame parser feeding the payload size counter
//
// Optional feature macro: PKT_HDR_PARSE_CHK_EN (header XOR checksum byte, handled in pkt_hdr_shift).
//
// Ports:
//   clock       in   system clock
//   rst_n       in   synchronous, active-low reset
//   in_valid    in   upstream byte valid
//   in_data     in   upstream byte
//   in_ready    out  byte accepted when in_valid & in_ready
//   last        in   final-beat flag from the size counter
//   size_valid  out  one-cycle pulse, size is valid
//   size        out  payload length in bytes, held until the next good header
//   data_start  out  one-cycle pulse on the first payload byte acceptance
//   out_valid   out  payload byte valid (registered)
//   out_data    out  payload byte
//   hdr_err     out  one-cycle pulse, header rejected
//   sync_err    out  one-cycle pulse, last misaligned with the internal count or payload gap
module pkt_hdr_parse
  import pkt_hdr_parse_pkg::*;
#(
  parameter int          SIZE_BYTES = 4,
  parameter logic [31:0] MAX_SIZE   = DEFAULT_MAX_SIZE
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        last,
  output logic        size_valid,
  output logic [31:0] size,
  output logic        data_start,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        hdr_err,
  output logic        sync_err
);

  state_t      state_q;
  state_t      state_d;

  logic        in_ready_q;
  logic [31:0] size_q;
  logic [31:0] rem_q;
  logic        first_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        hdr_err_q;
  logic        sync_err_q;

  logic        accept;
  logic        hdr_take;
  logic        pay_take;
  logic        hdr_done;
  logic [31:0] hdr_len;
  logic        chk_ok;
  logic        hdr_bad;
  logic        hdr_err_d;
  logic        sync_err_d;

  assign accept   = in_valid && in_ready_q;
  assign hdr_take = accept && (state_q == HDR);
  assign pay_take = accept && (state_q == PAY);

  pkt_hdr_shift #(
    .SIZE_BYTES (SIZE_BYTES)
  ) u_shift (
    .clock     (clock),
    .rst_n     (rst_n),
    .byte_take (hdr_take),
    .byte_data (in_data),
    .hdr_done  (hdr_done),
    .hdr_len   (hdr_len),
    .chk_ok    (chk_ok)
  );

  assign hdr_bad = (hdr_len == 32'd0) || (hdr_len > MAX_SIZE) || !chk_ok;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_err_d  = 1'b0;
    sync_err_d = 1'b0;
    case (state_q)
      HDR: begin
        if (hdr_done) begin
          if (hdr_bad) begin
            hdr_err_d = 1'b1;
          end else begin
            state_d = SIZE;
          end
        end
      end
      SIZE: begin
        state_d = PAY;
      end
      PAY: begin
        if (pay_take && (rem_q == 32'd1)) begin
          state_d = CHK;
        end
        // Once the payload has started the downstream counter runs every
        // cycle, so any hole in the byte stream breaks alignment.
        if (!in_valid && !first_q) begin
          sync_err_d = 1'b1;
        end
      end
      CHK: begin
        state_d = HDR;
        if (!last) begin
          sync_err_d = 1'b1;
        end
      end
      default: begin
        state_d = HDR;
      end
    endcase
    if (last && (state_q != CHK)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      size_q      <= 32'd0;
      rem_q       <= 32'd0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      hdr_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      // Registered from the next state so in_ready is low during reset and
      // drops on the SIZE and CHK cycles with no combinational path.
      in_ready_q  <= (state_d == HDR) || (state_d == PAY);
      hdr_err_q   <= hdr_err_d;
      sync_err_q  <= sync_err_d;
      out_valid_q <= pay_take;
      if (pay_take) begin
        out_data_q <= in_data;
      end
      if (hdr_done && !hdr_bad) begin
        size_q <= hdr_len;
      end
      if (state_q == SIZE) begin
        rem_q   <= size_q;
        first_q <= 1'b1;
      end else if (pay_take) begin
        rem_q   <= rem_q - 32'd1;
        first_q <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign size_valid = (state_q == SIZE);
  assign size       = size_q;
  assign data_start = pay_take && first_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign hdr_err    = hdr_err_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_pkt_hdr_parse.sv
// tb/tb_pkt_hdr_parse.sv - self-checking bench for pkt_hdr_parse
`timescale 1ns/1ps
module tb_pkt_hdr_parse;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        last;
  logic        size_valid;
  logic [31:0] size;
  logic        data_start;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        hdr_err;
  logic        sync_err;
  logic        last_force = 1'b0;

  always #5 clock = ~clock;

  pkt_hdr_parse dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .last       (last),
    .size_valid (size_valid),
    .size       (size),
    .data_start (data_start),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .hdr_err    (hdr_err),
    .sync_err   (sync_err)
  );

  // Size counter model: loads on size_valid, counts down per out beat.
  logic [31:0] cnt_model;
  always @(posedge clock) begin
    if (!rst_n) cnt_model <= 32'd0;
    else if (size_valid) cnt_model <= size;
    else if (out_valid && cnt_model != 32'd0) cnt_model <= cnt_model - 32'd1;
  end
  assign last = (out_valid && cnt_model == 32'd1) || last_force;

  // Monitor: cumulative event counts sampled mid-cycle.
  int m_sv = 0, m_ds = 0, m_ds_follow = 0, m_overlap = 0;
  int m_out = 0, m_hdr = 0, m_sync = 0, m_low = 0;
  logic prev_ds = 1'b0;
  logic [7:0] out_log [0:255];

  always begin
    @(negedge clock);
    #2;
    if (size_valid) m_sv++;
    if (data_start) m_ds++;
    if (data_start && size_valid) m_overlap++;
    if (out_valid) begin
      out_log[m_out % 256] = out_data;
      m_out++;
      if (prev_ds) m_ds_follow++;
    end
    if (hdr_err) m_hdr++;
    if (sync_err) m_sync++;
    if (!in_ready) m_low++;
    prev_ds = data_start;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] tx_buf [0:31];
  int tx_n;

  task automatic add_hdr(input logic [31:0] hdr);
    for (int i = 0; i < 4; i++) begin
      tx_buf[tx_n] = hdr[31-8*i -: 8];
      tx_n++;
    end
`ifdef PKT_HDR_PARSE_CHK_EN
    tx_buf[tx_n] = hdr[31:24] ^ hdr[23:16] ^ hdr[15:8] ^ hdr[7:0];
    tx_n++;
`endif
  endtask

  task automatic add_pay(input int npay, input logic [63:0] pay);
    for (int i = 0; i < npay; i++) begin
      tx_buf[tx_n] = pay[63-8*i -: 8];
      tx_n++;
    end
  endtask

  // Called at a negedge; streams tx_buf with in_valid held high.
  task automatic send();
    int i;
    int guard;
    logic acc;
    i = 0;
    guard = 0;
    while (i < tx_n && guard < 300) begin
      in_valid = 1'b1;
      in_data  = tx_buf[i];
      acc      = in_ready;
      @(negedge clock);
      if (acc) i++;
      guard++;
    end
    if (i < tx_n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: sent %0d of %0d bytes", i, tx_n);
    end
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  chk_flip;
    int          npay;
    logic [63:0] pay;
    int          e_sv;
    logic [31:0] e_size;
    int          e_out;
    int          e_hdr;
    int          e_sync;
    int          e_low;
  } vec_t;

  vec_t vec [0:5];
  int   nv;
  int s_sv, s_ds, s_dsf, s_ovl, s_out, s_hdr, s_sync, s_low;

  task automatic snap();
    s_sv = m_sv; s_ds = m_ds; s_dsf = m_ds_follow; s_ovl = m_overlap;
    s_out = m_out; s_hdr = m_hdr; s_sync = m_sync; s_low = m_low;
  endtask

  task automatic chk_out_bytes(input string tag, input int n, input logic [63:0] pay);
    for (int i = 0; i < n && i < (m_out - s_out); i++) begin
      chk($sformatf("%s out_data[%0d]", tag, i), {24'd0, out_log[(s_out + i) % 256]}, {24'd0, pay[63-8*i -: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{hdr:32'h0000_0003, chk_flip:8'h00, npay:3, pay:64'hAABBCC00_00000000,
               e_sv:1, e_size:32'd3, e_out:3, e_hdr:0, e_sync:0, e_low:2};
    vec[1] = '{hdr:32'h0000_0000, chk_flip:8'h00, npay:0, pay:64'h0,
               e_sv:0, e_size:32'd3, e_out:0, e_hdr:1, e_sync:0, e_low:0};
    vec[2] = '{hdr:32'h0000_0001, chk_flip:8'h00, npay:1, pay:64'h5A000000_00000000,
               e_sv:1, e_size:32'd1, e_out:1, e_hdr:0, e_sync:0, e_low:2};
    vec[3] = '{hdr:32'h0001_0000, chk_flip:8'h00, npay:0, pay:64'h0,
               e_sv:0, e_size:32'd1, e_out:0, e_hdr:1, e_sync:0, e_low:0};
    vec[4] = '{hdr:32'h0000_0002, chk_flip:8'h00, npay:2, pay:64'h12340000_00000000,
               e_sv:1, e_size:32'd2, e_out:2, e_hdr:0, e_sync:0, e_low:2};
    vec[5] = '{hdr:32'h0000_0002, chk_flip:8'h01, npay:0, pay:64'h0,
               e_sv:0, e_size:32'd2, e_out:0, e_hdr:1, e_sync:0, e_low:0};
`ifdef PKT_HDR_PARSE_CHK_EN
    nv = 6;
`else
    nv = 5;
`endif

    // Reset values, with a byte offered during reset.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(negedge clock);
    #2;
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst size_valid", {31'd0, size_valid}, 32'd0);
    chk("rst size", size, 32'd0);
    chk("rst data_start", {31'd0, data_start}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", {24'd0, out_data}, 32'd0);
    chk("rst hdr_err", {31'd0, hdr_err}, 32'd0);
    chk("rst sync_err", {31'd0, sync_err}, 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Table-driven single frames.
    for (int k = 0; k < nv; k++) begin
      snap();
      tx_n = 0;
      add_hdr(vec[k].hdr);
`ifdef PKT_HDR_PARSE_CHK_EN
      tx_buf[tx_n-1] = tx_buf[tx_n-1] ^ vec[k].chk_flip;
`endif
      add_pay(vec[k].npay, vec[k].pay);
      send();
      in_valid = 1'b0;
      repeat (6) @(negedge clock);
      chk($sformatf("v%0d size_valid", k), m_sv - s_sv, vec[k].e_sv);
      chk($sformatf("v%0d size", k), size, vec[k].e_size);
      chk($sformatf("v%0d out beats", k), m_out - s_out, vec[k].e_out);
      chk_out_bytes($sformatf("v%0d", k), vec[k].e_out, vec[k].pay);
      chk($sformatf("v%0d data_start", k), m_ds - s_ds, vec[k].e_sv);
      chk($sformatf("v%0d ds_before_beat", k), m_ds_follow - s_dsf, vec[k].e_sv);
      chk($sformatf("v%0d sv_ds_overlap", k), m_overlap - s_ovl, 32'd0);
      chk($sformatf("v%0d hdr_err", k), m_hdr - s_hdr, vec[k].e_hdr);
      chk($sformatf("v%0d sync_err", k), m_sync - s_sync, vec[k].e_sync);
      chk($sformatf("v%0d ready_low", k), m_low - s_low, vec[k].e_low);
    end

    // Back-to-back frames, len 2 then len 1, in_valid never dropped.
    snap();
    tx_n = 0;
    add_hdr(32'd2);
    add_pay(2, 64'h11220000_00000000);
    add_hdr(32'd1);
    add_pay(1, 64'h33000000_00000000);
    send();
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("b2b size_valid", m_sv - s_sv, 32'd2);
    chk("b2b out beats", m_out - s_out, 32'd3);
    chk_out_bytes("b2b", 3, 64'h11223300_00000000);
    chk("b2b ready_low", m_low - s_low, 32'd4);
    chk("b2b sync_err", m_sync - s_sync, 32'd0);
    chk("b2b hdr_err", m_hdr - s_hdr, 32'd0);

    // One-cycle in_valid gap inside a len 4 payload.
    snap();
    tx_n = 0;
    add_hdr(32'd4);
    add_pay(2, 64'h11220000_00000000);
    send();
    in_valid = 1'b0;
    @(negedge clock);
    tx_n = 0;
    add_pay(2, 64'h33440000_00000000);
    send();
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("gap sync_err", m_sync - s_sync, 32'd1);
    chk("gap out beats", m_out - s_out, 32'd4);
    chk_out_bytes("gap", 4, 64'h11223344_00000000);
    chk("gap back_in_hdr", {31'd0, in_ready}, 32'd1);
    chk("gap hdr_err", m_hdr - s_hdr, 32'd0);

    // last asserted while idle in HDR.
    snap();
    last_force = 1'b1;
    @(negedge clock);
    last_force = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_last sync_err", m_sync - s_sync, 32'd1);
    chk("idle_last in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_last size_valid", m_sv - s_sv, 32'd0);

    // Reset in the middle of a payload abandons the frame silently.
    tx_n = 0;
    add_hdr(32'd2);
    add_pay(1, 64'hEE000000_00000000);
    send();
    in_valid = 1'b0;
    snap();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("midrst errs", (m_hdr - s_hdr) + (m_sync - s_sync), 32'd0);
    chk("midrst size_cleared", size, 32'd0);
    snap();
    tx_n = 0;
    add_hdr(32'd1);
    add_pay(1, 64'h77000000_00000000);
    send();
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("midrst size_valid", m_sv - s_sv, 32'd1);
    chk("midrst size", size, 32'd1);
    chk("midrst out beats", m_out - s_out, 32'd1);
    chk_out_bytes("midrst", 1, 64'h77000000_00000000);
    chk("midrst errs_after", (m_hdr - s_hdr) + (m_sync - s_sync), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_hdr_parse.md
Name: pkt_hdr_parse

Overview:
- Upstream feeder for the payload size counter.
- Consumes a byte stream of [length header][payload] frames, assembles the big-endian length field, presents it as size/size_valid, pulses data_start ahead of the payload and forwards payload bytes.
- Cross-checks the counter's `last` against its own byte count and flags loss of sync.

Parameters:
- SIZE_BYTES, 4, number of header length bytes (1..4), MSB first; unused upper size bits are zero.
- MAX_SIZE, 32'h0000_FFFF, largest legal payload length; a larger length is a header error.

Ports:
- clock  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream byte
- in_ready  out  1  byte accepted when in_valid & in_ready
- last  in  1  final-beat flag from the size counter
- size_valid  out  1  one-cycle pulse, size is valid
- size  out  32  payload length in bytes
- data_start  out  1  one-cycle pulse, the cycle before the first out_valid beat
- out_valid  out  1  payload byte valid (registered)
- out_data  out  8  payload byte
- hdr_err  out  1  one-cycle pulse, header rejected
- sync_err  out  1  one-cycle pulse, `last` misaligned with the internal count

Behaviour:
- Reset values: in_ready=0, size_valid=0, size=0, data_start=0, out_valid=0, out_data=0, hdr_err=0, sync_err=0, state=HDR, counters=0.
- A reset asserted mid-frame abandons the frame. There is no output flush and no error pulse.
- HDR:
  - in_ready=1.
  - Each accepted byte shifts into the size register, MSB first.
  - The byte index counts 0..SIZE_BYTES-1.
  - On the last header byte:
    - length==0 or length>MAX_SIZE -> hdr_err pulse next cycle, stay in HDR, index cleared.
    - otherwise -> SIZE.
- SIZE:
  - Lasts one cycle with in_ready=0 and size_valid=1.
  - size holds the length until the next header completes.
  - Loads the internal remaining counter rem=size.
  - Next state PAY.
- PAY:
  - in_ready=1.
  - First accepted byte: data_start=1 combinationally in the same cycle.
  - Every accepted byte: out_valid/out_data registered, one cycle later; rem decrements.
  - The byte that makes rem reach 0 -> in_ready drops next cycle, go to CHK.
  - The source must keep in_valid high for the whole payload, because the counter decrements every cycle. An in_valid gap inside the payload produces sync_err.
- CHK:
  - Lasts one cycle with in_ready=0.
  - Expect last=1, coincident with the final out_valid beat.
  - last=0 -> sync_err pulse.
  - Either way go to HDR.
- last=1 in any state other than CHK -> sync_err pulse, state unchanged.
- size_valid and data_start are never asserted in the same cycle. data_start is at least one cycle after size_valid.
- Frame timing: the first payload byte may arrive the cycle after SIZE. Back-to-back frames cost 2 idle cycles (SIZE, CHK).

Optional Feature:
- Macro: PKT_HDR_PARSE_CHK_EN.
- Defined:
  - The header carries one extra byte: the XOR of the SIZE_BYTES length bytes.
  - A mismatch -> hdr_err, no size_valid, back to HDR.
  - The checksum byte is never forwarded.
- Undefined: no checksum byte; the header is exactly SIZE_BYTES long.

Decomposition:
- Shared package holds:
  - state encoding localparams HDR=2'b00, SIZE=2'b01, PAY=2'b11, CHK=2'b10;
  - default MAX_SIZE;
  - header byte-order constant.
- One natural sub-module, pkt_hdr_shift: the header shift/assemble register with byte index and optional XOR accumulator. The FSM and payload counter stay in the top.

Test Plan:
- Header 00 00 00 03, payload AA BB CC, connected to the size counter:
  - size_valid with size=3;
  - data_start one cycle before out_valid AA;
  - last on the CC beat;
  - no errors.
- Header 00 00 00 00 -> hdr_err pulse, no size_valid; the next valid header (len 1, byte 5A) parses normally.
- Header 00 01 00 00 (> MAX_SIZE) -> hdr_err, in_ready stays 1, no output beats.
- Two back-to-back frames (len 2, len 1) -> exactly 2 in_ready-low cycles between them; 3 out beats total; last on each frame's final beat.
- in_valid dropped for 1 cycle mid-payload (len 4) -> sync_err pulse; parser returns to HDR after the 4th byte.
- With PKT_HDR_PARSE_CHK_EN:
  - header 00 00 00 02 + checksum 02 -> accepted;
  - checksum 03 -> hdr_err, no size_valid.
